// File: rtl/regfile_wb_arbiter_if.sv
// regfile_wb_arbiter_if: bus bundle for the regfile write-port arbiter.
//   WB source     : wb_we, wb_wa, wb_wd
//   MC source     : mc_valid, mc_ready, mc_wa, mc_wd
//   Issue reserve : iss_valid, iss_wa
//   Decode check  : chk_ra1, chk_ra2, chk_wa, stall
//   Regfile port  : rf_we3, rf_wa3, rf_wd3
//   Scoreboard    : pending
// slave modport is the arbiter side; master is the surrounding pipeline.
interface regfile_wb_arbiter_if #(
   parameter int NREG = 32,
   parameter int DW   = 64,
   parameter int AW   = 5
);
   logic            wb_we;
   logic [AW-1:0]   wb_wa;
   logic [DW-1:0]   wb_wd;
   logic            mc_valid;
   logic            mc_ready;
   logic [AW-1:0]   mc_wa;
   logic [DW-1:0]   mc_wd;
   logic            iss_valid;
   logic [AW-1:0]   iss_wa;
   logic [AW-1:0]   chk_ra1;
   logic [AW-1:0]   chk_ra2;
   logic [AW-1:0]   chk_wa;
   logic            stall;
   logic            rf_we3;
   logic [AW-1:0]   rf_wa3;
   logic [DW-1:0]   rf_wd3;
   logic [NREG-1:0] pending;

   modport slave (
      input  wb_we, wb_wa, wb_wd, mc_valid, mc_wa, mc_wd,
             iss_valid, iss_wa, chk_ra1, chk_ra2, chk_wa,
      output mc_ready, stall, rf_we3, rf_wa3, rf_wd3, pending
   );

   modport master (
      output wb_we, wb_wa, wb_wd, mc_valid, mc_wa, mc_wd,
             iss_valid, iss_wa, chk_ra1, chk_ra2, chk_wa,
      input  mc_ready, stall, rf_we3, rf_wa3, rf_wd3, pending
   );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter: shares the single regfile write port between the
// pipeline WB stage and a multicycle (mul/div) unit.
//   clk     : clock, rising edge
//   reset_n : asynchronous active-low reset
//   bus     : regfile_wb_arbiter_if.slave (WB, MC handshake, issue
//             reservation, decode check/stall, regfile port, pending)
// WB always owns the port when it writes a real register; multicycle
// results wait in a small FIFO and drain on WB bubbles. A pending-dest
// scoreboard plus a starvation counter drive the decode stall.
// Optional: define REGFILE_WB_BYPASS_EN to let a multicycle result hit the
// port in its arrival cycle when the FIFO is empty and WB is idle.
module regfile_wb_arbiter #(
   parameter int NREG       = 32,
   parameter int DW         = 64,
   parameter int AW         = 5,
   parameter int BUF_DEPTH  = 2,
   parameter int STARVE_MAX = 4
) (
   input  logic                  clk,
   input  logic                  reset_n,
   regfile_wb_arbiter_if.slave   bus
);
   localparam logic [AW-1:0] ZR = AW'(NREG - 1);
   localparam int PW = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
   localparam int CW = $clog2(BUF_DEPTH + 1);
   localparam int SW = $clog2(STARVE_MAX + 1);

   logic [AW-1:0]   buf_wa [BUF_DEPTH];
   logic [DW-1:0]   buf_wd [BUF_DEPTH];
   logic [PW-1:0]   rd_ptr, wr_ptr;
   logic [CW-1:0]   count;
   logic [SW-1:0]   starve_cnt;
   logic [NREG-1:0] pend_q, pend_d;

   logic wb_claim, empty, full, deq, enq, bypass, mc_write, starve;

   assign wb_claim = bus.wb_we && (bus.wb_wa != ZR);
   assign empty    = (count == '0);
   assign full     = (count == CW'(BUF_DEPTH));
   assign deq      = !wb_claim && !empty;

`ifdef REGFILE_WB_BYPASS_EN
   assign bypass   = !wb_claim && empty && bus.mc_valid && (bus.mc_wa != ZR);
`else
   assign bypass   = 1'b0;
`endif

   // Zero-register results complete the handshake but are never stored.
   assign enq      = bus.mc_valid && !full && (bus.mc_wa != ZR) && !bypass;
   assign mc_write = deq || bypass;
   assign starve   = (starve_cnt == SW'(STARVE_MAX));

   assign bus.mc_ready = !full;
   assign bus.pending  = pend_q;

   // Write-port mux; gated by reset so the port is quiet while held.
   always_comb begin
      bus.rf_we3 = 1'b0;
      bus.rf_wa3 = '0;
      bus.rf_wd3 = '0;
      if (reset_n) begin
         if (wb_claim) begin
            bus.rf_we3 = 1'b1;
            bus.rf_wa3 = bus.wb_wa;
            bus.rf_wd3 = bus.wb_wd;
         end else if (deq) begin
            bus.rf_we3 = 1'b1;
            bus.rf_wa3 = buf_wa[rd_ptr];
            bus.rf_wd3 = buf_wd[rd_ptr];
         end else if (bypass) begin
            bus.rf_we3 = 1'b1;
            bus.rf_wa3 = bus.mc_wa;
            bus.rf_wd3 = bus.mc_wd;
         end
      end
   end

   // Clear first, then set, so a same-cycle set on the same index wins.
   always_comb begin
      pend_d = pend_q;
      if (mc_write)
         pend_d[bus.rf_wa3] = 1'b0;
      if (bus.iss_valid && (bus.iss_wa != ZR))
         pend_d[bus.iss_wa] = 1'b1;
   end

   always_comb begin
      bus.stall = starve
         || ((bus.chk_ra1 != ZR) && pend_q[bus.chk_ra1])
         || ((bus.chk_ra2 != ZR) && pend_q[bus.chk_ra2])
         || ((bus.chk_wa  != ZR) && pend_q[bus.chk_wa]);
   end

   // Payload storage needs no reset; occupancy is tracked by count.
   always_ff @(posedge clk) begin
      if (enq) begin
         buf_wa[wr_ptr] <= bus.mc_wa;
         buf_wd[wr_ptr] <= bus.mc_wd;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         rd_ptr     <= '0;
         wr_ptr     <= '0;
         count      <= '0;
         starve_cnt <= '0;
         pend_q     <= '0;
      end else begin
         pend_q <= pend_d;
         if (enq) wr_ptr <= wr_ptr + PW'(1);
         if (deq) rd_ptr <= rd_ptr + PW'(1);
         case ({enq, deq})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
         // Count only cycles where a buffered head lost the port to WB.
         if (empty || deq)
            starve_cnt <= '0;
         else if (wb_claim && !starve)
            starve_cnt <= starve_cnt + SW'(1);
      end
   end
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb_regfile_wb_arbiter: directed bench for regfile_wb_arbiter. Expected
// regfile writes go into a queue as stimulus is driven; a negedge monitor
// pops and compares every observed write. Directed checks cover reset,
// stall, starvation, full buffer, zero register and bypass latency.
module tb_regfile_wb_arbiter;
   localparam int NREG = 32;
   localparam int DW   = 64;
   localparam int AW   = 5;

   logic clk;
   logic reset_n;
   int   tests = 0;
   int   fails = 0;
   logic [AW+DW-1:0] exp_q [$];

   regfile_wb_arbiter_if #(.NREG(NREG), .DW(DW), .AW(AW)) bus ();

   regfile_wb_arbiter #(.NREG(NREG), .DW(DW), .AW(AW), .BUF_DEPTH(2),
                        .STARVE_MAX(4)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      #2;
   endtask

   task automatic expw(input logic [AW-1:0] wa, input logic [DW-1:0] wd);
      exp_q.push_back({wa, wd});
   endtask

   task automatic idle();
      bus.wb_we = 0; bus.wb_wa = '0; bus.wb_wd = '0;
      bus.mc_valid = 0; bus.mc_wa = '0; bus.mc_wd = '0;
      bus.iss_valid = 0; bus.iss_wa = '0;
      bus.chk_ra1 = '0; bus.chk_ra2 = '0; bus.chk_wa = '0;
   endtask

   task automatic wb(input logic [AW-1:0] wa, input logic [DW-1:0] wd, input bit expect_it);
      bus.wb_we = 1; bus.wb_wa = wa; bus.wb_wd = wd;
      if (expect_it) expw(wa, wd);
   endtask

   task automatic mc(input logic [AW-1:0] wa, input logic [DW-1:0] wd);
      bus.mc_valid = 1; bus.mc_wa = wa; bus.mc_wd = wd;
   endtask

   // Scoreboard monitor: every write must match the next expected one.
   always @(negedge clk) begin
      if (bus.rf_we3 === 1'b1) begin
         tests++;
         if (exp_q.size() == 0) begin
            fails++;
            $error("FAIL unexpected_write: got wa=%0d wd=%0h expected no write", bus.rf_wa3, bus.rf_wd3);
         end else begin
            logic [AW+DW-1:0] e;
            e = exp_q.pop_front();
            assert ({bus.rf_wa3, bus.rf_wd3} === e) else begin
               fails++;
               $error("FAIL write_data: got wa=%0d wd=%0h expected wa=%0d wd=%0h",
                      bus.rf_wa3, bus.rf_wd3, e[AW+DW-1:DW], e[DW-1:0]);
            end
         end
      end
      // Issuing to an already-reserved register is illegal stimulus.
      if (reset_n && bus.iss_valid && bus.iss_wa != AW'(NREG-1)) begin
         tests++;
         assert (bus.pending[bus.iss_wa] === 1'b0) else begin
            fails++;
            $error("FAIL iss_to_pending: got pending[%0d]=1 expected 0", bus.iss_wa);
         end
      end
   end

   initial begin
      idle();
      reset_n = 0;
      #2;
      chk("reset_we3",     64'(bus.rf_we3), 64'd0);
      chk("reset_pending", 64'(bus.pending), 64'd0);
      chk("reset_stall",   64'(bus.stall), 64'd0);
      tick(); reset_n = 1; settle();
      chk("rel_mc_ready",  64'(bus.mc_ready), 64'd1);

      // --- reset mid-operation with two buffered results ---
      tick(); bus.iss_valid = 1; bus.iss_wa = 1;
      tick(); bus.iss_wa = 2; wb(10, 64'h100, 1); mc(1, 64'h11);
      tick(); bus.iss_valid = 0; wb(11, 64'h101, 1); mc(2, 64'h22);
      tick(); bus.mc_valid = 0; wb(12, 64'h102, 0); #1;
      chk("full_mc_ready", 64'(bus.mc_ready), 64'd0);
      chk("pend_0x6",      64'(bus.pending), 64'h6);
      reset_n = 0; #1;
      chk("midrst_we3",     64'(bus.rf_we3), 64'd0);
      chk("midrst_pending", 64'(bus.pending), 64'd0);
      tick(); idle(); reset_n = 1; settle();
      chk("post_rst_ready", 64'(bus.mc_ready), 64'd1);
      chk("post_rst_we3",   64'(bus.rf_we3), 64'd0);

      // --- RAW stall on pending X5 ---
      tick(); bus.iss_valid = 1; bus.iss_wa = 5; bus.chk_ra1 = 5; settle();
      chk("raw_stall_pre", 64'(bus.stall), 64'd0);
      tick(); bus.iss_valid = 0; settle();
      chk("raw_stall_on",  64'(bus.stall), 64'd1);
      chk("raw_pending",   64'(bus.pending), 64'h20);
      tick(); mc(5, 64'h1234);
`ifdef REGFILE_WB_BYPASS_EN
      expw(5, 64'h1234); settle();
      chk("bypass_we3_now", 64'(bus.rf_we3), 64'd1);
`else
      settle();
      chk("nobypass_we3_now", 64'(bus.rf_we3), 64'd0);
`endif
      chk("raw_stall_mc", 64'(bus.stall), 64'd1);
      tick(); bus.mc_valid = 0;
`ifdef REGFILE_WB_BYPASS_EN
      settle();
      chk("bypass_stall_off", 64'(bus.stall), 64'd0);
`else
      expw(5, 64'h1234); settle();
      chk("drain_we3",    64'(bus.rf_we3), 64'd1);
      chk("drain_wa3",    64'(bus.rf_wa3), 64'd5);
      chk("stall_hold",   64'(bus.stall), 64'd1);
`endif
      tick(); settle();
      chk("raw_stall_off", 64'(bus.stall), 64'd0);
      bus.chk_ra1 = 0;

      // --- starvation: X9 buffered behind continuous WB ---
      tick(); bus.iss_valid = 1; bus.iss_wa = 9;
      tick(); bus.iss_valid = 0; wb(1, 64'h1001, 1); mc(9, 64'h9999);
      for (int i = 2; i <= 8; i++) begin
         tick(); bus.mc_valid = 0; wb(AW'(i), 64'h1000 + 64'(i), 1); settle();
         if (i == 5) chk("starve_not_yet", 64'(bus.stall), 64'd0);
         if (i == 6) chk("starve_stall",   64'(bus.stall), 64'd1);
         if (i == 8) chk("starve_hold",    64'(bus.stall), 64'd1);
      end
      tick(); bus.wb_we = 0; expw(9, 64'h9999); settle();
      chk("starve_drain_wa", 64'(bus.rf_wa3), 64'd9);
      tick(); settle();
      chk("starve_clear",   64'(bus.stall), 64'd0);
      chk("starve_pending", 64'(bus.pending), 64'd0);

      // --- full buffer, held result, simultaneous enq/deq ---
      tick(); wb(20, 64'h2000, 1); mc(21, 64'h21); settle();
      chk("fill_ready0", 64'(bus.mc_ready), 64'd1);
      tick(); wb(22, 64'h2002, 1); mc(23, 64'h23);
      tick(); wb(24, 64'h2004, 1); mc(25, 64'h25); settle();
      chk("full_ready", 64'(bus.mc_ready), 64'd0);
      tick(); wb(26, 64'h2006, 1); settle();
      chk("held_ready", 64'(bus.mc_ready), 64'd0);
      tick(); bus.wb_we = 0; expw(21, 64'h21); settle();
      chk("deq_ready_reg", 64'(bus.mc_ready), 64'd0);
      tick(); expw(23, 64'h23); settle();
      chk("simul_ready", 64'(bus.mc_ready), 64'd1);
      tick(); wb(27, 64'h2007, 1); mc(29, 64'h29);
      tick(); bus.mc_valid = 0; bus.wb_we = 0; expw(25, 64'h25); settle();
      chk("occ2_ready", 64'(bus.mc_ready), 64'd0);
      tick(); expw(29, 64'h29); settle();
      chk("drained_ready", 64'(bus.mc_ready), 64'd1);
      tick(); settle();
      chk("idle_we3", 64'(bus.rf_we3), 64'd0);

      // --- zero register handling ---
      tick(); wb(10, 64'h3010, 1); mc(3, 64'h333);
      tick(); bus.mc_valid = 0; wb(31, 64'hDEAD, 0); expw(3, 64'h333); settle();
      chk("zr_wb_head_wa", 64'(bus.rf_wa3), 64'd3);
      tick(); bus.wb_we = 0; mc(31, 64'hBEEF); settle();
      chk("zr_mc_ready", 64'(bus.mc_ready), 64'd1);
      chk("zr_mc_nowr",  64'(bus.rf_we3), 64'd0);
      tick(); bus.mc_valid = 0; bus.iss_valid = 1; bus.iss_wa = 31;
      bus.chk_ra1 = 31; bus.chk_ra2 = 31; bus.chk_wa = 31; settle();
      chk("zr_mc_dropped", 64'(bus.rf_we3), 64'd0);
      tick(); bus.iss_valid = 0; settle();
      chk("zr_pending", 64'(bus.pending), 64'd0);
      chk("zr_stall",   64'(bus.stall), 64'd0);

      // --- WAW stall via chk_wa, then clear ---
      tick(); bus.iss_valid = 1; bus.iss_wa = 6; bus.chk_ra1 = 0; bus.chk_ra2 = 0; bus.chk_wa = 6;
      tick(); bus.iss_valid = 0; settle();
      chk("waw_stall", 64'(bus.stall), 64'd1);
      tick(); mc(6, 64'h66);
`ifdef REGFILE_WB_BYPASS_EN
      expw(6, 64'h66);
      tick(); bus.mc_valid = 0;
`else
      tick(); bus.mc_valid = 0; expw(6, 64'h66);
`endif
      tick(); settle();
      chk("waw_clear", 64'(bus.stall), 64'd0);
      idle();

      tick(); tick();
      chk("queue_empty", 64'(exp_q.size()), 64'd0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule

// File: doc/regfile_wb_arbiter.md
Name: regfile_wb_arbiter

Overview:
- Shares the single register-file write port (we3/wa3/wd3) between two sources:
  - the pipeline writeback stage;
  - a long-latency multicycle unit (multiply/divide).
- Multicycle results go into a small buffer until the port is free.
- A pending-destination scoreboard drives a decode stall, so reads and writes never race an outstanding multicycle result.
- Sits between the WB stage, the multicycle unit, decode, and the regfile write port.

Parameters:
- NREG, 32, number of architectural registers; index NREG-1 (X31) is the hard-wired zero register.
- DW, 64, data width.
- AW, 5, register address width.
- BUF_DEPTH, 2, multicycle result buffer entries (power of two, ≥2).
- STARVE_MAX, 4, cycles a buffered head may wait before a drain stall is forced.

Ports:
- clk  in  1  clock; all state changes on rising edge.
- reset_n  in  1  asynchronous active-low reset.
- wb_we  in  1  pipeline writeback valid.
- wb_wa  in  AW  pipeline writeback register.
- wb_wd  in  DW  pipeline writeback data.
- mc_valid  in  1  multicycle result valid.
- mc_ready  out  1  result accepted this cycle.
- mc_wa  in  AW  multicycle destination.
- mc_wd  in  DW  multicycle result data.
- iss_valid  in  1  multicycle op issued this cycle; reserves iss_wa.
- iss_wa  in  AW  destination reserved at issue.
- chk_ra1  in  AW  decode source 1.
- chk_ra2  in  AW  decode source 2.
- chk_wa  in  AW  decode destination (WAW check).
- stall  out  1  freeze fetch/decode.
- rf_we3  out  1  regfile write enable.
- rf_wa3  out  AW  regfile write address.
- rf_wd3  out  DW  regfile write data.
- pending  out  NREG  scoreboard vector.

Behaviour:
- Reset (reset_n low, asynchronous):
  - buffer empty, pending = 0, starve counter = 0;
  - stall = 0, rf_we3 = 0, rf_wa3 = 0, rf_wd3 = 0;
  - mc_ready = 1 once reset_n is high.
  - Reset mid-operation discards buffered results and all reservations.
- Zero register:
  - any write targeting NREG-1 is dropped and never asserts rf_we3;
  - iss_wa = NREG-1 sets no pending bit;
  - chk_* = NREG-1 never stalls.
- Write port mux (combinational from current inputs and buffer head; zero added latency):
  - wb_we && wb_wa != NREG-1 → port = WB.
  - Else, buffer non-empty → port = buffer head; dequeue at clock edge.
  - Else → rf_we3 = 0.
  - WB always wins: the pipeline cannot be held at WB.
- Buffer:
  - FIFO, BUF_DEPTH entries; mc_ready = !full (registered state only, never depends on same-cycle dequeue).
  - Enqueue on mc_valid && mc_ready.
  - mc_wa = NREG-1 is accepted and discarded (handshake still completes).
  - Simultaneous enqueue and dequeue are legal; occupancy unchanged.
  - Pointers wrap modulo BUF_DEPTH.
- Scoreboard:
  - iss_valid sets pending[iss_wa].
  - A buffer-head write to the regfile clears pending[rf_wa3].
  - Set and clear of the same index in one cycle: set wins.
  - iss_valid to an already-pending register is illegal (bench assertion).
- Starvation:
  - Counter increments each cycle the buffer is non-empty and WB takes the port.
  - Resets to 0 on any dequeue or when empty.
  - Saturates at STARVE_MAX.
  - starve = (counter == STARVE_MAX).
- stall (combinational) = pending[chk_ra1] || pending[chk_ra2] || pending[chk_wa] || starve.
  - Zero-register indices are excluded from every term.
  - With starve, stall persists until WB bubbles let the buffer drain.

Optional Feature:
- Macro: REGFILE_WB_BYPASS_EN.
- Defined: when the buffer is empty, mc_valid is high, and WB does not claim the port, mc_wa/mc_wd drive the port in the same cycle without enqueueing.
  - pending clears that edge.
  - mc_ready stays 1.
- Undefined: every multicycle result passes through the buffer, so a result reaches the regfile no earlier than the cycle after acceptance.

Test Plan:
- Reset with buffer holding 2 entries and pending = 0x0000_0006, then reset_n low mid-cycle → outputs 0 immediately, pending = 0, mc_ready = 1 after release.
- iss_valid with iss_wa = 5; decode chk_ra1 = 5 → stall = 1 until mc result X5 = 0x1234 is written; stall drops the cycle after rf_we3 with rf_wa3 = 5.
- wb_we continuous (X1..X8) while mc result X9 is buffered → WB owns the port; after STARVE_MAX = 4 cycles stall = 1; first wb_we = 0 cycle writes X9 and clears the counter.
- Two mc results accepted with continuous WB → mc_ready = 0 while full; third result held until a dequeue; simultaneous enqueue/dequeue keeps occupancy at 2.
- wb_wa = 31 with wb_we = 1 and buffer head X3 → X3 written that cycle; mc_wa = 31 accepted, no write, no pending change.
- REGFILE_WB_BYPASS_EN defined, idle WB, empty buffer, mc X7 = 0xDEAD → rf_we3 same cycle; undefined → rf_we3 one cycle later.
